// File: rtl/id_stage.sv
// RV32I instruction-decode stage: control decode, immediate generation,
// 32x32 register file with WB write-through, load-use hazard and flush bubbles.
module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] INSTR_ID,
  input  logic [31:0] PC_IF_ID,
  input  logic        RegWrite_WB,
  input  logic [4:0]  RD_WB,
  input  logic [31:0] WB_DATA,
  input  logic        MemRead_EX,
  input  logic [4:0]  RD_EX,
  input  logic        flush,
  output logic [31:0] IMM_ID,
  output logic [31:0] REG_DATA1_ID,
  output logic [31:0] REG_DATA2_ID,
  output logic        RegWrite_ID,
  output logic        MemtoReg_ID,
  output logic        MemRead_ID,
  output logic        MemWrite_ID,
  output logic        ALUsrc_ID,
  output logic        Branch_ID,
  output logic [1:0]  ALUop_ID,
  output logic [31:0] PC_ID,
  output logic [6:0]  FUNCT7_ID,
  output logic [2:0]  FUNCT3_ID,
  output logic [4:0]  RD_ID,
  output logic [4:0]  RS1_ID,
  output logic [4:0]  RS2_ID,
  output logic        pc_write,
  output logic        if_id_write,
  output logic [31:0] stall_count
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011
  } opcode_e;

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] stall_count_q, stall_count_d;

  logic        wb_en;
  logic        hazard;
  logic        bubble;
  logic [7:0]  ctrl;  // {RegWrite,MemtoReg,MemRead,MemWrite,ALUsrc,Branch,ALUop}

  assign RD_ID     = INSTR_ID[11:7];
  assign RS1_ID    = INSTR_ID[19:15];
  assign RS2_ID    = INSTR_ID[24:20];
  assign FUNCT3_ID = INSTR_ID[14:12];
  assign FUNCT7_ID = INSTR_ID[31:25];
  assign PC_ID     = PC_IF_ID;

  assign wb_en  = RegWrite_WB && (RD_WB != 5'd0);
  assign hazard = MemRead_EX && (RD_EX != 5'd0) &&
                  ((RD_EX == RS1_ID) || (RD_EX == RS2_ID));
  assign bubble = hazard || flush;

  assign pc_write    = !hazard;
  assign if_id_write = !hazard;
  assign stall_count = stall_count_q;

  always_comb begin
    ctrl   = '0;
    IMM_ID = '0;
    case (INSTR_ID[6:0])
      OP_R: ctrl = 8'b1_0_0_0_0_0_10;
      OP_IALU: begin
        ctrl   = 8'b1_0_0_0_1_0_11;
        IMM_ID = {{20{INSTR_ID[31]}}, INSTR_ID[31:20]};
      end
      OP_LOAD: begin
        ctrl   = 8'b1_1_1_0_1_0_00;
        IMM_ID = {{20{INSTR_ID[31]}}, INSTR_ID[31:20]};
      end
      OP_STORE: begin
        ctrl   = 8'b0_0_0_1_1_0_00;
        IMM_ID = {{20{INSTR_ID[31]}}, INSTR_ID[31:25], INSTR_ID[11:7]};
      end
      OP_BRANCH: begin
        ctrl   = 8'b0_0_0_0_0_1_01;
        IMM_ID = {{19{INSTR_ID[31]}}, INSTR_ID[31], INSTR_ID[7],
                  INSTR_ID[30:25], INSTR_ID[11:8], 1'b0};
      end
      default: ctrl = '0;
    endcase
    if (bubble) ctrl = '0;
  end

  assign {RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID,
          ALUsrc_ID, Branch_ID, ALUop_ID} = ctrl;

  // x0 is forced to zero on read; the pending WB write takes priority over the array.
  function automatic logic [31:0] read_port(input logic [4:0] rs);
    if (rs == 5'd0)                 return '0;
    else if (wb_en && RD_WB == rs)  return WB_DATA;
    else                            return regs_q[rs];
  endfunction

  always_comb begin
    REG_DATA1_ID = read_port(RS1_ID);
    REG_DATA2_ID = read_port(RS2_ID);
  end

  always_comb begin
    regs_d = regs_q;
    if (reset) begin
      for (int unsigned i = 0; i < 32; i++) regs_d[i] = '0;
    end else if (wb_en) begin
      regs_d[RD_WB] = WB_DATA;
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (reset)                                stall_count_d = '0;
    else if (hazard && stall_count_q != '1)   stall_count_d = stall_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    regs_q        <= regs_d;
    stall_count_q <= stall_count_d;
  end

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed test-plan cycles followed by random
// cycles, all checked against a spec-level reference model.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] INSTR_ID, PC_IF_ID, WB_DATA;
  logic        RegWrite_WB, MemRead_EX, flush;
  logic [4:0]  RD_WB, RD_EX;
  logic [31:0] IMM_ID, REG_DATA1_ID, REG_DATA2_ID, PC_ID, stall_count;
  logic        RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUsrc_ID, Branch_ID;
  logic [1:0]  ALUop_ID;
  logic [6:0]  FUNCT7_ID;
  logic [2:0]  FUNCT3_ID;
  logic [4:0]  RD_ID, RS1_ID, RS2_ID;
  logic        pc_write, if_id_write;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .INSTR_ID(INSTR_ID), .PC_IF_ID(PC_IF_ID),
    .RegWrite_WB(RegWrite_WB), .RD_WB(RD_WB), .WB_DATA(WB_DATA),
    .MemRead_EX(MemRead_EX), .RD_EX(RD_EX), .flush(flush),
    .IMM_ID(IMM_ID), .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
    .RegWrite_ID(RegWrite_ID), .MemtoReg_ID(MemtoReg_ID), .MemRead_ID(MemRead_ID),
    .MemWrite_ID(MemWrite_ID), .ALUsrc_ID(ALUsrc_ID), .Branch_ID(Branch_ID),
    .ALUop_ID(ALUop_ID), .PC_ID(PC_ID), .FUNCT7_ID(FUNCT7_ID), .FUNCT3_ID(FUNCT3_ID),
    .RD_ID(RD_ID), .RS1_ID(RS1_ID), .RS2_ID(RS2_ID),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_count(stall_count)
  );

  typedef struct {
    logic [31:0] imm, rd1, rd2, pc, stall;
    logic [7:0]  ctrl;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rd, rs1, rs2;
    logic        pcw, ifw;
  } exp_t;

  exp_t        sb_q[$];
  event        sample_ev;
  int          errors = 0;
  int          checks = 0;

  logic [31:0] m_regs [32];
  longint      m_stall;

  function automatic logic [31:0] m_read(input logic [4:0] rs);
    if (rs == 0) return 32'd0;
    if (RegWrite_WB && RD_WB != 0 && RD_WB == rs) return WB_DATA;
    return m_regs[rs];
  endfunction

  function automatic exp_t model();
    exp_t e;
    logic [6:0] op;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    logic signed [12:0] b13;
    logic haz;
    op  = INSTR_ID[6:0];
    i12 = INSTR_ID[31:20];
    s12 = {INSTR_ID[31:25], INSTR_ID[11:7]};
    b13 = {INSTR_ID[31], INSTR_ID[7], INSTR_ID[30:25], INSTR_ID[11:8], 1'b0};
    e.rs1 = INSTR_ID[19:15];
    e.rs2 = INSTR_ID[24:20];
    e.rd  = INSTR_ID[11:7];
    e.f3  = INSTR_ID[14:12];
    e.f7  = INSTR_ID[31:25];
    e.pc  = PC_IF_ID;
    case (op)
      7'b0110011: begin e.ctrl = 8'b10000010; e.imm = 0; end
      7'b0010011: begin e.ctrl = 8'b10001011; e.imm = int'(i12); end
      7'b0000011: begin e.ctrl = 8'b11101000; e.imm = int'(i12); end
      7'b0100011: begin e.ctrl = 8'b00011000; e.imm = int'(s12); end
      7'b1100011: begin e.ctrl = 8'b00000101; e.imm = int'(b13); end
      default:    begin e.ctrl = 8'b00000000; e.imm = 0; end
    endcase
    haz = MemRead_EX && RD_EX != 0 && (RD_EX == e.rs1 || RD_EX == e.rs2);
    if (haz || flush) e.ctrl = 8'd0;
    e.pcw   = !haz;
    e.ifw   = !haz;
    e.rd1   = m_read(e.rs1);
    e.rd2   = m_read(e.rs2);
    e.stall = m_stall[31:0];
    return e;
  endfunction

  // Called right after a falling edge with inputs already set.
  task automatic step();
    logic haz;
    sb_q.push_back(model());
    -> sample_ev;
    haz = MemRead_EX && RD_EX != 0 && (RD_EX == INSTR_ID[19:15] || RD_EX == INSTR_ID[24:20]);
    @(posedge clk);
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 0;
      m_stall = 0;
    end else begin
      if (RegWrite_WB && RD_WB != 0) m_regs[RD_WB] = WB_DATA;
      if (haz && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(sample_ev);
      #1;
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("IMM_ID", IMM_ID, e.imm);
        chk("REG_DATA1_ID", REG_DATA1_ID, e.rd1);
        chk("REG_DATA2_ID", REG_DATA2_ID, e.rd2);
        chk("ctrl", {24'd0, RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID,
                     ALUsrc_ID, Branch_ID, ALUop_ID}, {24'd0, e.ctrl});
        chk("PC_ID", PC_ID, e.pc);
        chk("fields", {12'd0, FUNCT7_ID, FUNCT3_ID, RD_ID, RS1_ID, RS2_ID},
                      {12'd0, e.f7, e.f3, e.rd, e.rs1, e.rs2});
        chk("pc_write", {31'd0, pc_write}, {31'd0, e.pcw});
        chk("if_id_write", {31'd0, if_id_write}, {31'd0, e.ifw});
        chk("stall_count", stall_count, e.stall);
      end
    end
  end

  task automatic set_in(input logic [31:0] instr, input logic rw, input logic [4:0] rdwb,
                        input logic [31:0] wbd, input logic mr, input logic [4:0] rdex,
                        input logic fl, input logic rst);
    INSTR_ID = instr; PC_IF_ID = $urandom; RegWrite_WB = rw; RD_WB = rdwb; WB_DATA = wbd;
    MemRead_EX = mr; RD_EX = rdex; flush = fl; reset = rst;
  endtask

  initial begin : stim
    logic [6:0] ops [6];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111};
    foreach (m_regs[i]) m_regs[i] = 0;
    m_stall = 0;
    set_in(32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1);
    @(negedge clk);
    // First reset edge: DUT state is unknown until it lands, so nothing is checked.
    @(posedge clk);
    @(negedge clk);

    set_in(32'h0000_0033, 0, 0, 0, 0, 0, 0, 0);            step(); // add x0,x0,x0
    set_in(32'h0000_0033, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0); step(); // WB x5
    set_in(32'h0052_80B3, 1, 0, 32'h1234, 0, 0, 0, 0);     step(); // add x1,x5,x5 / WB x0
    set_in(32'h0000_0033, 0, 0, 0, 0, 0, 0, 0);            step();
    set_in(32'h0003_80B3, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0); step(); // bypass x7
    set_in(32'h0003_80B3, 0, 0, 0, 0, 0, 0, 0);            step();
    set_in(32'hFFC1_2083, 0, 0, 0, 0, 0, 0, 0);            step(); // lw -4
    set_in(32'hFE31_2C23, 0, 0, 0, 0, 0, 0, 0);            step(); // sw -8
    set_in(32'h0020_8863, 0, 0, 0, 0, 0, 0, 0);            step(); // beq +16
    set_in(32'h0021_8233, 0, 0, 0, 1, 3, 0, 0);            step(); // load-use
    set_in(32'h0021_8233, 0, 0, 0, 1, 0, 0, 0);            step(); // RD_EX=0
    set_in(32'h0021_8233, 0, 0, 0, 0, 0, 1, 0);            step(); // flush
    set_in(32'h0021_8233, 0, 0, 0, 1, 2, 1, 0);            step(); // hazard+flush
    for (int i = 0; i < 3; i++) begin
      set_in(32'h0021_8233, 0, 0, 0, 1, 3, 0, 0);          step();
    end
    set_in(32'h0052_80B3, 1, 9, 32'h55, 0, 0, 0, 1);       step(); // reset at 5, WB dropped
    set_in(32'h0052_80B3, 0, 0, 0, 0, 0, 0, 0);            step();

    for (int n = 0; n < 2000; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 5)];
      set_in(ins, 1'($urandom), 5'($urandom), $urandom, ($urandom_range(0, 2) == 0),
             5'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 99) == 0));
      if ($urandom_range(0, 2) == 0) RD_EX = $urandom_range(0, 1) ? ins[19:15] : ins[24:20];
      if ($urandom_range(0, 2) == 0) RD_WB = $urandom_range(0, 1) ? ins[19:15] : ins[24:20];
      step();
    end

    #2;
    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID pipeline register and the ID/EX pipeline register. It decodes the instruction, generates the immediate, and reads the 32x32 register file, which it owns and which is written from WB. It also performs load-use hazard detection (stall/bubble) and honours branch flushes from EX. Every output named *_ID feeds the same-named input of the ID/EX register directly.

## Interface
- Parameters: none (XLEN fixed at 32, 32 architectural registers).
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears register file and stall counter
- INSTR_ID  in  32  instruction from IF/ID
- PC_IF_ID  in  32  PC from IF/ID
- RegWrite_WB  in  1  WB write enable
- RD_WB  in  5  WB destination register
- WB_DATA  in  32  WB write data
- MemRead_EX  in  1  ID/EX MemRead output (load in EX)
- RD_EX  in  5  ID/EX RD output
- flush  in  1  taken branch resolved in EX; squash instruction in ID
- IMM_ID  out  32  sign-extended immediate
- REG_DATA1_ID, REG_DATA2_ID  out  32 each  rs1/rs2 read data
- RegWrite_ID, MemtoReg_ID, MemRead_ID, MemWrite_ID, ALUsrc_ID, Branch_ID  out  1 each  control
- ALUop_ID  out  2  ALU op class
- PC_ID  out  32  PC_IF_ID passed through
- FUNCT7_ID  out  7  INSTR_ID[31:25]
- FUNCT3_ID  out  3  INSTR_ID[14:12]
- RD_ID, RS1_ID, RS2_ID  out  5 each  INSTR_ID[11:7], [19:15], [24:20]
- pc_write  out  1  0 = hold PC
- if_id_write  out  1  0 = hold IF/ID
- stall_count  out  32  load-use stall cycles since reset

## Operation
- Decode by opcode INSTR_ID[6:0], control listed as RegWrite/MemtoReg/MemRead/MemWrite/ALUsrc/Branch/ALUop:
  - 0110011 (R): 1/0/0/0/0/0/10
  - 0010011 (I-ALU): 1/0/0/0/1/0/11
  - 0000011 (load): 1/1/1/0/1/0/00
  - 0100011 (store): 0/0/0/1/1/0/00
  - 1100011 (branch): 0/0/0/0/0/1/01
  - any other opcode: all zero (NOP)
- Immediate formats:
  - I (loads, I-ALU): sext(INSTR[31:20])
  - S: sext({INSTR[31:25],INSTR[11:7]})
  - B: sext({INSTR[31],INSTR[7],INSTR[30:25],INSTR[11:8],1'b0}), a byte offset
  - other opcodes: 0
- Register file reads:
  - Combinational read of rs1 and rs2.
  - x0 always reads 0.
  - Write-through: if RegWrite_WB && RD_WB!=0 && RD_WB==rsN, REG_DATAN_ID = WB_DATA in the same cycle.
- Register file write: at posedge when RegWrite_WB && RD_WB!=0 and reset is low. Writes to x0 are discarded.
- Load-use hazard: hazard = MemRead_EX && RD_EX!=0 && (RD_EX==RS1_ID || RD_EX==RS2_ID).
  - The check applies to both source fields regardless of opcode; false stalls are accepted.
- Bubble condition: hazard || flush. On a bubble, all control outputs (RegWrite through ALUop) are forced to 0. Data, PC, funct and register-index outputs keep their decoded values.
- pc_write = if_id_write = !hazard. flush does not deassert them.
- stall_count: +1 at each posedge where hazard=1 and reset=0; saturates at 0xFFFFFFFF.

## Timing
- Decode, immediate, read data, hazard and bubble logic are all combinational: zero-cycle latency from INSTR_ID / ID/EX outputs. Values are captured by ID/EX at the next edge.
- A write at edge N is visible through the array from N onward. Before edge N it is visible through the write-through bypass.
- A load-use hazard lasts exactly one cycle in a normal pipeline: after the bubble enters ID/EX, MemRead_EX=0.
- Simultaneous hazard and flush: controls are zeroed, pc_write=0, and the stall is counted. The flush still squashes the instruction; refetch is IF's responsibility.
- Reset (synchronous, may occur mid-operation):
  - At the first edge with reset=1, all 31 registers and stall_count clear to 0.
  - A WB write in the same cycle is dropped.
  - Outputs are combinational on registers/inputs, so after reset REG_DATA*_ID read 0. pc_write and if_id_write follow inputs, so they are 1 when MemRead_EX=0.

## Test plan
- Reset, then INSTR_ID=0x00000033 (add x0,x0,x0) -> RegWrite_ID=1, ALUop_ID=10, REG_DATA1/2_ID=0, stall_count=0.
- Write x5=0xDEADBEEF via WB, next cycle decode add x1,x5,x5 -> REG_DATA1/2_ID=0xDEADBEEF. Attempt WB write x0=0x1234 -> rs1=x0 reads 0.
- Same-cycle bypass: RegWrite_WB=1, RD_WB=7, WB_DATA=0xA5A5A5A5 while decoding rs1=x7 -> REG_DATA1_ID=0xA5A5A5A5 in that cycle.
- Immediates:
  - lw with imm field 0xFFC -> IMM_ID=0xFFFFFFFC, MemRead_ID=1, MemtoReg_ID=1, ALUsrc_ID=1.
  - sw with offset -8 -> IMM_ID=0xFFFFFFF8.
  - beq with offset +16 -> IMM_ID=0x00000010, Branch_ID=1, ALUop_ID=01.
- Load-use: MemRead_EX=1, RD_EX=3, decoding add x4,x3,x2 -> pc_write=0, if_id_write=0, all controls 0, stall_count 0->1. With RD_EX=0, no stall.
- flush=1 with a valid R-type instruction -> all controls 0, pc_write=1. Asserting reset mid-run with stall_count=5 -> 0 after the edge.
